// File: rtl/arb_pkg.sv
// arb_pkg: arbiter state, requester class and grant record types
package arb_pkg;
  localparam int CORE_W = 8;
  typedef enum logic {IDLE, ACCESS} arb_state_t;
  typedef enum logic {CLS_D, CLS_I} arb_class_t;
  typedef struct packed {
    arb_class_t         cls;
    logic [CORE_W-1:0]  core;
  } grant_t;
  function automatic logic [CORE_W-1:0] rr_next(input logic [CORE_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction
endpackage

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word and RAM handshake types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: rotate-priority encoder, first set request at or after ptr wins
module rr_picker
  import arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]      req_i,
  input  logic [CORE_W-1:0] ptr_i,
  output logic              valid_o,
  output logic [CORE_W-1:0] idx_o
);
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        valid_o = 1'b1;
        idx_o   = CORE_W'((int'(ptr_i) + k) % N);
      end
    end
  end
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one RAM port among NCORES icache/dcache pairs, dcache first.
// Define ARB_PERF_EN to add per-requester saturating grant counters.
module cache_mem_arbiter
  import arb_pkg::*;
#(
  parameter int NCORES = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NCORES-1:0]        iREN,
  input  logic [NCORES*ADDR_W-1:0] iaddr,
  output logic [NCORES-1:0]        iwait,
  output logic [NCORES*DATA_W-1:0] iload,
  input  logic [NCORES-1:0]        dREN,
  input  logic [NCORES-1:0]        dWEN,
  input  logic [NCORES*ADDR_W-1:0] daddr,
  input  logic [NCORES*DATA_W-1:0] dstore,
  output logic [NCORES-1:0]        dwait,
  output logic [NCORES*DATA_W-1:0] dload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [DATA_W-1:0]        ramstore,
  input  logic [DATA_W-1:0]        ramload,
  input  logic [1:0]               ramstate
`ifdef ARB_PERF_EN
  ,
  output logic [NCORES*32-1:0]     perf_igrant,
  output logic [NCORES*32-1:0]     perf_dgrant
`endif
);
  localparam int IW = NCORES > 1 ? $clog2(NCORES) : 1;
  arb_state_t        state_q, state_d;
  grant_t            grant_q, grant_d;
  logic [CORE_W-1:0] dptr_q, dptr_d, iptr_q, iptr_d, didx, iidx;
  logic [NCORES-1:0] dreq;
  logic [IW-1:0]     gc;
  logic              dv, iv, live, hit;
  assign dreq  = dREN | dWEN;
  assign iload = {NCORES{ramload}};
  assign dload = {NCORES{ramload}};
  assign gc    = grant_q.core[IW-1:0];
  // A granted requester that drops its request aborts the access.
  assign live  = state_q == ACCESS && (grant_q.cls == CLS_D ? dreq[gc] : iREN[gc]);
  assign hit   = live && ramstate == cpu_types_pkg::ACCESS;
  rr_picker #(.N(NCORES)) u_dpick (.req_i(dreq), .ptr_i(dptr_q), .valid_o(dv), .idx_o(didx));
  rr_picker #(.N(NCORES)) u_ipick (.req_i(iREN), .ptr_i(iptr_q), .valid_o(iv), .idx_o(iidx));
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    dptr_d   = dptr_q;
    iptr_d   = iptr_q;
    iwait    = '1;
    dwait    = '1;
    ramWEN   = live && grant_q.cls == CLS_D && dWEN[gc];
    ramREN   = live && !ramWEN;
    ramaddr  = !live ? '0 : grant_q.cls == CLS_D ? daddr[gc*ADDR_W +: ADDR_W] : iaddr[gc*ADDR_W +: ADDR_W];
    ramstore = (live && grant_q.cls == CLS_D) ? dstore[gc*DATA_W +: DATA_W] : '0;
    if (state_q == IDLE && (dv || iv)) begin
      state_d      = ACCESS;
      grant_d.cls  = dv ? CLS_D : CLS_I;
      grant_d.core = dv ? didx : iidx;
    end else if (state_q == ACCESS && (!live || hit)) begin
      state_d = IDLE;
    end
    if (hit) begin
      dwait[gc] = grant_q.cls == CLS_I;
      iwait[gc] = grant_q.cls == CLS_D;
      dptr_d    = grant_q.cls == CLS_D ? rr_next(grant_q.core, NCORES) : dptr_q;
      iptr_d    = grant_q.cls == CLS_I ? rr_next(grant_q.core, NCORES) : iptr_q;
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      grant_q <= '0;
      dptr_q  <= '0;
      iptr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      dptr_q  <= dptr_d;
      iptr_q  <= iptr_d;
    end
  end
`ifdef ARB_PERF_EN
  logic [NCORES*32-1:0] perf_i_q, perf_d_q;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_i_q <= '0;
      perf_d_q <= '0;
    end else begin
      for (int c = 0; c < NCORES; c++) begin
        if (!iwait[c] && perf_i_q[c*32 +: 32] != '1) perf_i_q[c*32 +: 32] <= perf_i_q[c*32 +: 32] + 32'd1;
        if (!dwait[c] && perf_d_q[c*32 +: 32] != '1) perf_d_q[c*32 +: 32] <= perf_d_q[c*32 +: 32] + 32'd1;
      end
    end
  end
  assign perf_igrant = perf_i_q;
  assign perf_dgrant = perf_d_q;
`endif
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed cases then random traffic against a transaction-level model
module tb_cache_mem_arbiter;
  localparam int N = 2, AW = 32, DW = 32;
  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACC = 2'd2;
  logic CLK = 1'b0, nRST;
  logic [N-1:0] iREN, dREN, dWEN, iwait, dwait;
  logic [N*AW-1:0] iaddr, daddr;
  logic [N*DW-1:0] dstore, iload, dload;
  logic ramREN, ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore, ramload;
  logic [1:0] ramstate;
`ifdef ARB_PERF_EN
  logic [N*32-1:0] perf_igrant, perf_dgrant;
`endif
  int total = 0, bad = 0;
  // Model: one outstanding grant (class 0 = dcache, 1 = icache), per-class pointers, grant counts
  bit m_busy;
  int m_cls, m_core;
  int ptr[2];
  longint unsigned cnt[2][N];
  logic [N-1:0] last_iw, last_dw;
  cache_mem_arbiter #(.NCORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef ARB_PERF_EN
    , .perf_igrant(perf_igrant), .perf_dgrant(perf_dgrant)
`endif
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit req_of(input int cls, input int c);
    return cls == 0 ? (dREN[c] | dWEN[c]) : iREN[c];
  endfunction
  task automatic model_reset();
    m_busy = 0;
    ptr = '{0, 0};
    foreach (cnt[a, b]) cnt[a][b] = 0;
  endtask
  // One clock: inputs already driven at the negedge; check, advance model at posedge, return at next negedge.
  task automatic step();
    bit live, hit, wr;
    logic [N-1:0] eiw, edw;
    #1;
    live = m_busy && req_of(m_cls, m_core);
    hit  = live && ramstate == RS_ACC;
    wr   = live && m_cls == 0 && dWEN[m_core];
    eiw = '1;
    edw = '1;
    if (hit && m_cls == 1) eiw[m_core] = 1'b0;
    if (hit && m_cls == 0) edw[m_core] = 1'b0;
    check("iwait", iwait, eiw);
    check("dwait", dwait, edw);
    check("ramWEN", ramWEN, wr);
    check("ramREN", ramREN, live && !wr);
    check("ramaddr", ramaddr, !live ? 32'd0 : (m_cls == 1 ? iaddr[m_core*AW +: AW] : daddr[m_core*AW +: AW]));
    check("ramstore", ramstore, (live && m_cls == 0) ? dstore[m_core*DW +: DW] : 32'd0);
    check("iload", iload, {N{ramload}});
    check("dload", dload, {N{ramload}});
`ifdef ARB_PERF_EN
    for (int c = 0; c < N; c++) begin
      check("perf_i", perf_igrant[c*32 +: 32], cnt[1][c]);
      check("perf_d", perf_dgrant[c*32 +: 32], cnt[0][c]);
    end
`endif
    last_iw = iwait;
    last_dw = dwait;
    @(posedge CLK);
    if (!m_busy) begin
      for (int cls = 0; cls < 2 && !m_busy; cls++)
        for (int off = 0; off < N && !m_busy; off++)
          if (req_of(cls, (ptr[cls] + off) % N)) begin
            m_busy = 1;
            m_cls  = cls;
            m_core = (ptr[cls] + off) % N;
          end
    end else if (!live) begin
      m_busy = 0;
    end else if (hit) begin
      ptr[m_cls] = (m_core + 1) % N;
      if (cnt[m_cls][m_core] != 64'hFFFF_FFFF) cnt[m_cls][m_core]++;
      m_busy = 0;
    end
    @(negedge CLK);
  endtask
  initial begin
    int r;
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = RS_FREE;
    model_reset();
    #12;
    check("rst_iwait", iwait, 2'b11);
    check("rst_dwait", dwait, 2'b11);
    check("rst_ramREN", ramREN, 1'b0);
    check("rst_ramWEN", ramWEN, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (3) step();
    // single icache read, zero-latency RAM
    iREN = 2'b01; iaddr[0 +: AW] = 32'h40; ramstate = RS_ACC; ramload = 32'h1234_5678;
    step();
    #1;
    check("t2_addr", ramaddr, 32'h40);
    check("t2_ren", ramREN, 1'b1);
    check("t2_iwait", iwait, 2'b10);
    check("t2_iload", iload[0 +: DW], 32'h1234_5678);
    step();
    iREN = '0;
    step();
    // dcache write beats a simultaneous icache read
    iREN = 2'b01; iaddr[0 +: AW] = 32'h100;
    dWEN = 2'b10; daddr[AW +: AW] = 32'h80; dstore[DW +: DW] = 32'hDEAD_BEEF;
    step();
    #1;
    check("t3_wen", ramWEN, 1'b1);
    check("t3_ren", ramREN, 1'b0);
    check("t3_store", ramstore, 32'hDEAD_BEEF);
    check("t3_daddr", ramaddr, 32'h80);
    check("t3_dwait", dwait, 2'b01);
    step();
    dWEN = '0;
    step();
    #1;
    check("t3_iaddr", ramaddr, 32'h100);
    check("t3_iwait", iwait, 2'b10);
    step();
    iREN = '0;
    step();
    // two dcaches held, 2-cycle RAM: alternating grants
    dREN = 2'b11; daddr = {32'h2000, 32'h1000};
    for (int g = 0; g < 4; g++) begin
      ramstate = RS_BUSY;
      step();
      step();
      ramstate = RS_ACC;
      #1;
      check("t4_order", dwait, (g % 2 == 0) ? 2'b10 : 2'b01);
      step();
    end
    dREN = '0;
    step();
    // aborted grant leaves the pointer alone
    dREN = 2'b01;
    step();
    step();
    dREN = 2'b10; ramstate = RS_BUSY;
    step();
    step();
    dREN = 2'b00;
    #1;
    check("t5_dwait", dwait, 2'b11);
    step();
    #1;
    check("t5_idle", ramREN, 1'b0);
    step();
    dREN = 2'b11; ramstate = RS_ACC;
    step();
    #1;
    check("t5_ptr", dwait, 2'b01);
    step();
    dREN = '0;
    step();
    // asynchronous reset in the middle of an access
    iREN = 2'b10; iaddr[AW +: AW] = 32'hC0;
    step();
    #1;
    check("t6_pre", ramREN, 1'b1);
    nRST = 1'b0;
    #1;
    check("t6_ren", ramREN, 1'b0);
    check("t6_iwait", iwait, 2'b11);
    check("t6_addr", ramaddr, 32'd0);
`ifdef ARB_PERF_EN
    check("t6_perf_i", perf_igrant, 64'd0);
    check("t6_perf_d", perf_dgrant, 64'd0);
`endif
    model_reset();
    iREN = '0;
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    step();
    // random traffic: caches hold until served, sometimes abort
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (!last_iw[c] || (!iREN[c] && $urandom_range(0, 3) == 0)) begin
          iREN[c] = 1'($urandom_range(0, 1));
          iaddr[c*AW +: AW] = $urandom;
        end else if (iREN[c] && $urandom_range(0, 31) == 0) begin
          iREN[c] = 1'b0;
        end
        if (!last_dw[c] || (!(dREN[c] | dWEN[c]) && $urandom_range(0, 3) == 0)) begin
          r = (!last_dw[c] && $urandom_range(0, 1) == 0) ? 3 : int'($urandom_range(0, 2));
          dREN[c] = r == 0 || r == 2;
          dWEN[c] = r == 1 || r == 2;
          daddr[c*AW +: AW] = $urandom;
          dstore[c*DW +: DW] = $urandom;
        end else if ((dREN[c] | dWEN[c]) && $urandom_range(0, 31) == 0) begin
          dREN[c] = 1'b0;
          dWEN[c] = 1'b0;
        end
      end
      ramstate = $urandom_range(0, 1) ? RS_ACC : 2'($urandom_range(0, 3));
      ramload = $urandom;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
